// File: rtl/load_store_unit.sv
// Load/store stage: one data-memory transaction per request over req/gnt/rvalid,
// with byte-lane steering for stores and align/extend for loads.

module lsu_byte_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,   // funct3[1:0]: 00 byte, 01 half, 10 word
  input  logic [1:0] lane,   // ea[1:0]
  input  logic [7:0] b0,     // store_data[7:0]
  input  logic [7:0] b1,     // store_data[15:8]
  input  logic [7:0] bown,   // store_data byte that belongs to this lane
  output logic       strb,
  output logic [7:0] wbyte
);
  localparam logic [1:0] LANE_ID = 2'(LANE);

  always_comb begin
    strb  = 1'b0;
    wbyte = 8'h00;
    case (size)
      2'b00: begin
        strb  = (lane == LANE_ID);
        wbyte = b0;
      end
      2'b01: begin
        strb  = (lane[1] == LANE_ID[1]);
        wbyte = LANE_ID[0] ? b1 : b0;
      end
      2'b10: begin
        strb  = 1'b1;
        wbyte = bown;
      end
      default: ;
    endcase
  end
endmodule

module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] write_back,
  output logic [4:0]  reg_dest,
  output logic        write_en
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_e;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] ea;
    logic [31:0] sdata;
  } lsu_req_t;

  state_e      state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic        fault_q, fault_d;
  logic [31:0] ldata_q, ldata_d;

  logic [31:0] ea;
  logic        bad_req;

  function automatic logic illegal_f3(input logic st, input logic [2:0] f3);
    if (st) return (f3 > 3'b010);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

  assign ea      = base + offset;
  assign bad_req = illegal_f3(is_store, funct3) || misaligned(funct3, ea[1:0]);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    fault_d = 1'b0;
    ldata_d = ldata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          req_d = '{is_store: is_store, funct3: funct3, rd: rd, ea: ea, sdata: store_data};
          if (bad_req) fault_d = 1'b1;
          else         state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = req_q.is_store ? S_WB : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          ldata_d = mem_rdata >> {req_q.ea[1:0], 3'b000};
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      fault_q <= 1'b0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      fault_q <= fault_d;
      ldata_q <= ldata_d;
    end
  end

  // Store byte steering, one slice per memory byte lane
  logic [NUM_LANES-1:0]      lane_strb;
  logic [NUM_LANES-1:0][7:0] lane_wdata;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_byte_lane #(.LANE(g)) u_lane (
      .size  (req_q.funct3[1:0]),
      .lane  (req_q.ea[1:0]),
      .b0    (req_q.sdata[7:0]),
      .b1    (req_q.sdata[15:8]),
      .bown  (req_q.sdata[8*g +: 8]),
      .strb  (lane_strb[g]),
      .wbyte (lane_wdata[g])
    );
  end

  logic [31:0] ext_data;

  always_comb begin
    ext_data = ldata_q;
    case (req_q.funct3)
      3'b000:  ext_data = {{24{ldata_q[7]}},  ldata_q[7:0]};
      3'b001:  ext_data = {{16{ldata_q[15]}}, ldata_q[15:0]};
      3'b100:  ext_data = {24'h0, ldata_q[7:0]};
      3'b101:  ext_data = {16'h0, ldata_q[15:0]};
      default: ext_data = ldata_q;
    endcase
  end

  logic in_req, in_wb, st_req;

  assign in_req = (state_q == S_REQ);
  assign in_wb  = (state_q == S_WB);
  assign st_req = in_req && req_q.is_store;

  // Bus outputs are forced to zero outside REQ so an aborted or idle unit drives nothing
  assign busy       = (state_q != S_IDLE);
  assign done       = in_wb;
  assign fault      = fault_q;
  assign mem_req    = in_req;
  assign mem_we     = st_req;
  assign mem_addr   = in_req ? {req_q.ea[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = st_req ? lane_wdata : 32'h0;
  assign mem_wstrb  = st_req ? lane_strb  : 4'h0;
  assign write_en   = in_wb && !req_q.is_store && (req_q.rd != 5'd0);
  assign write_back = write_en ? ext_data : 32'h0;
  assign reg_dest   = write_en ? req_q.rd : 5'd0;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store stage of the Reg_Imm_Mem core. It sits between the register file's read ports and its write port. It takes the base register value, sign-extended immediate and store data, and runs one data-memory transaction over a req/gnt/rvalid handshake. For loads it aligns and extends the returned data and presents it on write_back/reg_dest/write_en for the register file.

## Interface
- No parameters; data path is 32-bit and register index is 5-bit, both fixed.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0, ignored otherwise.
- is_store  in  1  1 = store, 0 = load; sampled with start.
- funct3  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- base  in  32  rs1 value (register file read_data1).
- offset  in  32  sign-extended immediate.
- store_data  in  32  rs2 value (register file read_data2).
- rd  in  5  load destination register.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  one-cycle pulse: misaligned address or illegal funct3; no access performed.
- mem_req  out  1  memory request, held until granted.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables; 0000 for loads.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- write_back  out  32  load result to the register file.
- reg_dest  out  5  destination index.
- write_en  out  1  register file write strobe, one cycle.

## Operation
- States: IDLE, REQ, WAIT, WB.
- Effective address: ea = base + offset, modulo 2^32, with carry discarded.
- On accepted start, latch the following: is_store, funct3, rd, store_data, and ea.
  - On misalignment or illegal funct3, stay in IDLE and pulse fault in the next cycle.
  - Otherwise go to REQ.
- Misalignment cases:
  - Halfword with ea[0]=1.
  - Word with ea[1:0] != 00.
- Illegal funct3 values:
  - Loads: 011, 110, 111.
  - Stores: any funct3 other than 000, 001, 010.
- mem_addr = {ea[31:2], 2'b00}. Lane = ea[1:0].
- Store lanes and data:
  - SB: wstrb = 0001 << lane; wdata = byte replicated x4.
  - SH: wstrb = 0011 << lane; wdata = halfword replicated x2.
  - SW: wstrb = 1111; wdata = store_data.
- REQ state:
  - mem_req=1, with mem_we/addr/wdata/wstrb held stable until mem_gnt.
  - On gnt: a store goes to WB; a load goes to WAIT.
- WAIT state: on mem_rvalid, capture mem_rdata >> (8*lane), then go to WB.
- Load extension of the captured data:
  - LB / LH: sign-extend from bit 7 / 15.
  - LBU / LHU: zero-extend.
  - LW: full word.
- WB state:
  - done=1 for one cycle, then return to IDLE.
  - For loads with rd != 0: write_en=1, write_back = extended data, reg_dest = rd.
  - For stores, or loads with rd=0: write_en=0.
- Ignored inputs:
  - mem_gnt outside REQ.
  - mem_rvalid outside WAIT.
  - start while busy.

## Timing
- Reset (rst=0) acts immediately and asynchronously:
  - State goes to IDLE.
  - Every output goes to 0: busy, done, fault, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, write_back, reg_dest, write_en.
  - All latched registers are cleared.
- Reset mid-transaction aborts it: mem_req drops in the same cycle, no write or done is issued, and a later rvalid is ignored.
- Outputs are decoded from registered state and latches; there are no combinational paths from inputs to outputs.
- Minimum load latency, with gnt in the first REQ cycle and rvalid in the next cycle:
  - Start at cycle 0.
  - REQ at cycle 1.
  - WAIT at cycle 2.
  - WB (write_en/done) at cycle 3.
- Minimum store latency: start at cycle 0, REQ at cycle 1, WB/done at cycle 2.
- Fault pulses at cycle 1; busy stays 0 throughout.
- A new start is accepted in the cycle after WB, when busy=0.
- Throughput: one transaction in flight at most.

## Test plan
- LW: base=0x100, offset=4, rd=5, immediate gnt, rvalid next cycle with rdata=0xDEADBEEF.
  - Expect mem_addr=0x104 and wstrb=0000.
  - Cycle 3: write_en=1, write_back=0xDEADBEEF, reg_dest=5, done=1.
- LB and LBU at ea=0x103 with rdata=0x80FF1234: LB → write_back=0xFFFFFF80; LBU → write_back=0x00000080.
- SH: ea=0x202, store_data=0x1234ABCD, gnt held off for 3 cycles.
  - Expect mem_req stable for 3 cycles with mem_addr=0x200, wdata=0xABCDABCD, wstrb=1100.
  - done one cycle after gnt; write_en stays 0.
- Faults: LW at ea=0x102, and funct3=011 load.
  - fault pulses one cycle after start; mem_req never asserts; busy=0.
- Reset in WAIT: drive rst=0 during WAIT, then release and deliver rvalid=1.
  - All outputs read 0 at once; no write_en or done afterwards.
  - The next LW completes normally.
- LW with rd=0, plus start pulsed while busy.
  - The access completes and done=1 with write_en=0.
  - The second start is ignored, with no extra mem_req.
